// File: rtl/round_key_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : round_key_ctrl_if
// Purpose  : Key-load, expander and read-port signal bundle for round_key_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface round_key_ctrl_if #(
  parameter int KEY_W = 128
);
  // key load
  logic [KEY_W-1:0] key_i;
  logic             key_valid;
  logic             key_ready;
  // expander side
  logic             exp_en;
  logic [KEY_W-1:0] exp_key;
  logic [KEY_W-1:0] exp_round_key;
  logic             exp_w_e;
  logic [3:0]       exp_round_no;
  logic             exp_done;
  logic             keys_valid;
  // read port
  logic             req0;
  logic             req1;
  logic [3:0]       req0_round;
  logic [3:0]       req1_round;
  logic             gnt0;
  logic             gnt1;
  logic [KEY_W-1:0] rd_key;
  logic             rd_valid;
  logic             rd_id;
  logic             rd_err;

  modport master (
    output key_i, key_valid, exp_round_key, exp_w_e, exp_round_no, exp_done,
           req0, req1, req0_round, req1_round,
    input  key_ready, exp_en, exp_key, keys_valid, gnt0, gnt1,
           rd_key, rd_valid, rd_id, rd_err
  );

  modport slave (
    input  key_i, key_valid, exp_round_key, exp_w_e, exp_round_no, exp_done,
           req0, req1, req0_round, req1_round,
    output key_ready, exp_en, exp_key, keys_valid, gnt0, gnt1,
           rd_key, rd_valid, rd_id, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/round_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : round_key_ctrl
// Purpose  : Round-key store fed by an external expander, read by two
//            round-robin requesters. ROUND_KEY_CTRL_ZEROIZE_EN adds zeroize.
// Revision : 1.0 - initial release
// ============================================================================
module round_key_ctrl #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  wire logic       clk,
  input  wire logic       reset,
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
  input  wire logic       zeroize,
`endif
  round_key_ctrl_if.slave kbus
);

  localparam int unsigned C_LAST  = NR;
  localparam int          C_DEPTH = NR + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    S_READY  = 2'd2,
    S_DRAIN  = 2'd3
`else
    S_READY  = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             exp_en_q, exp_en_d;
  logic [KEY_W-1:0] exp_key_q, exp_key_d;
  logic             keys_valid_q, keys_valid_d;
  logic             rr_last_q, rr_last_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_id_q, rd_id_d;
  logic             rd_err_q, rd_err_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic [KEY_W-1:0] store_q [0:NR];

  logic             w_zeroize;
  logic             w_key_ready;
  logic             w_load;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_wr_en;
  logic [3:0]       w_rd_round;

`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      exp_en_q     <= 1'b0;
      exp_key_q    <= '0;
      keys_valid_q <= 1'b0;
      rr_last_q    <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_key_q     <= '0;
    end else begin
      state_q      <= state_d;
      exp_en_q     <= exp_en_d;
      exp_key_q    <= exp_key_d;
      keys_valid_q <= keys_valid_d;
      rr_last_q    <= rr_last_d;
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
      rd_err_q     <= rd_err_d;
      rd_key_q     <= rd_key_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) store_q[i] <= '0;
    end else if (w_zeroize) begin
      for (int i = 0; i < C_DEPTH; i++) store_q[i] <= '0;
    end else if (w_wr_en) begin
      store_q[kbus.exp_round_no] <= kbus.exp_round_key;
    end
  end

  always_comb begin
    state_d      = state_q;
    exp_en_d     = 1'b0;
    exp_key_d    = exp_key_q;
    keys_valid_d = keys_valid_q;
    rr_last_d    = rr_last_q;
    rd_valid_d   = 1'b0;
    rd_id_d      = rd_id_q;
    rd_err_d     = rd_err_q;
    rd_key_d     = rd_key_q;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_round   = kbus.req0_round;
    w_key_ready  = (state_q == S_IDLE) || (state_q == S_READY);
    // a simultaneous zeroize suppresses the load
    w_load       = kbus.key_valid && w_key_ready && !w_zeroize;

    case (state_q)
      S_IDLE: begin
        if (w_load) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        w_wr_en = kbus.exp_w_e && (32'(kbus.exp_round_no) <= C_LAST) && !w_zeroize;
        if (kbus.exp_done) begin
          state_d      = S_READY;
          keys_valid_d = 1'b1;
        end
      end
      S_READY: begin
        if (w_load) begin
          state_d = S_EXPAND;
        end else if (!w_zeroize) begin
          if (kbus.req0 && kbus.req1) begin
            w_gnt0 = rr_last_q;
            w_gnt1 = !rr_last_q;
          end else begin
            w_gnt0 = kbus.req0;
            w_gnt1 = kbus.req1;
          end
        end
      end
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
      S_DRAIN: begin
        if (kbus.exp_done) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (w_load) begin
      exp_key_d    = kbus.key_i;
      exp_en_d     = 1'b1;
      keys_valid_d = 1'b0;
    end

    if (w_gnt0 || w_gnt1) begin
      rr_last_d  = w_gnt1;
      rd_valid_d = 1'b1;
      rd_id_d    = w_gnt1;
      w_rd_round = w_gnt1 ? kbus.req1_round : kbus.req0_round;
      if (32'(w_rd_round) > C_LAST) begin
        rd_err_d = 1'b1;
        rd_key_d = '0;
      end else begin
        rd_err_d = 1'b0;
        rd_key_d = store_q[w_rd_round];
      end
    end

`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    // an expansion in flight must still finish on the expander side, so drain it
    if (w_zeroize) begin
      exp_key_d    = '0;
      exp_en_d     = 1'b0;
      keys_valid_d = 1'b0;
      if ((state_q == S_EXPAND) || (state_q == S_DRAIN)) begin
        state_d = kbus.exp_done ? S_IDLE : S_DRAIN;
      end else begin
        state_d = S_IDLE;
      end
    end
`endif
  end

  assign kbus.key_ready  = w_key_ready;
  assign kbus.exp_en     = exp_en_q;
  assign kbus.exp_key    = exp_key_q;
  assign kbus.keys_valid = keys_valid_q;
  assign kbus.gnt0       = w_gnt0;
  assign kbus.gnt1       = w_gnt1;
  assign kbus.rd_key     = rd_key_q;
  assign kbus.rd_valid   = rd_valid_q;
  assign kbus.rd_id      = rd_id_q;
  assign kbus.rd_err     = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_round_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_key_ctrl
// Purpose  : Directed bench for round_key_ctrl with an AES-128 reference
//            expander; zeroize sequence runs when ROUND_KEY_CTRL_ZEROIZE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_key_ctrl;

  localparam logic [127:0] C_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic reset;
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
  logic zeroize;
`endif
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] rk [0:10];

  typedef struct {
    logic         r0;
    logic [3:0]   r0n;
    logic         r1;
    logic [3:0]   r1n;
    logic         g0;
    logic         g1;
    logic         rv;
    logic         rid;
    logic         rerr;
    logic [127:0] key;
  } vec_t;
  vec_t tbl [11];

  round_key_ctrl_if #(.KEY_W(128)) bus();

  round_key_ctrl #(.NR(10), .KEY_W(128)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .kbus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- AES-128 reference key schedule ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) b = 8'(i);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic vec_t mk(input logic r0, input logic [3:0] r0n, input logic r1,
                              input logic [3:0] r1n, input logic g0, input logic g1,
                              input logic rv, input logic rid, input logic rerr,
                              input logic [127:0] key);
    vec_t v;
    v.r0 = r0; v.r0n = r0n; v.r1 = r1; v.r1n = r1n; v.g0 = g0; v.g1 = g1;
    v.rv = rv; v.rid = rid; v.rerr = rerr; v.key = key;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_exp_en"},     bus.exp_en, 0);
    check({tag, "_keys_valid"}, bus.keys_valid, 0);
    check({tag, "_gnt"},        {bus.gnt0, bus.gnt1}, 0);
    check({tag, "_rd_valid"},   bus.rd_valid, 0);
    check({tag, "_rd_id"},      bus.rd_id, 0);
    check({tag, "_rd_err"},     bus.rd_err, 0);
    check({tag, "_rd_key"},     bus.rd_key, 0);
    check({tag, "_exp_key"},    bus.exp_key, 0);
  endtask

  task automatic accept_key(input logic [127:0] k);
    bus.key_valid = 1'b1;
    bus.key_i     = k;
    #1;
    check("key_ready_at_load", bus.key_ready, 1);
    check("no_grant_on_load", {bus.gnt0, bus.gnt1}, 0);
    tick();
    bus.key_valid = 1'b0;
    check("exp_en_pulse", bus.exp_en, 1);
    check("exp_key_latched", bus.exp_key, k);
    check("keys_valid_cleared", bus.keys_valid, 0);
    check("key_ready_low_expand", bus.key_ready, 0);
    check("no_grant_after_load", {bus.gnt0, bus.gnt1}, 0);
    tick();
    check("exp_en_single", bus.exp_en, 0);
  endtask

  // present rounds 0..last; when stop_at is reached the round is left driven and we return
  task automatic expand(input int last, input int stop_at);
    for (int r = 0; r <= last; r++) begin
      bus.exp_w_e       = 1'b1;
      bus.exp_round_no  = 4'(r);
      bus.exp_round_key = rk[r];
      bus.exp_done      = (r == last);
      if (r == stop_at) return;
      #1;
      check("no_grant_expand", {bus.gnt0, bus.gnt1}, 0);
      check("exp_en_quiet", bus.exp_en, 0);
      check("keys_valid_during_expand", bus.keys_valid, 0);
      tick();
    end
    bus.exp_w_e  = 1'b0;
    bus.exp_done = 1'b0;
    check("keys_valid_set", bus.keys_valid, 1);
  endtask

  task automatic read0(input logic [3:0] rnd, input logic [127:0] exp_key, input logic exp_err);
    bus.req0       = 1'b1;
    bus.req0_round = rnd;
    #1;
    check("read_gnt0", bus.gnt0, 1);
    tick();
    bus.req0 = 1'b0;
    check("read_rd_valid", bus.rd_valid, 1);
    check("read_rd_err", bus.rd_err, exp_err);
    check("read_rd_key", bus.rd_key, exp_key);
  endtask

  initial begin
    reset             = 1'b1;
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    zeroize           = 1'b0;
`endif
    bus.key_i         = '0;
    bus.key_valid     = 1'b0;
    bus.exp_round_key = '0;
    bus.exp_w_e       = 1'b0;
    bus.exp_round_no  = 4'd0;
    bus.exp_done      = 1'b0;
    bus.req0          = 1'b0;
    bus.req1          = 1'b0;
    bus.req0_round    = 4'd0;
    bus.req1_round    = 4'd0;

    build_schedule(C_KEY);

    tbl[0]  = mk(1'b1, 4'd3,  1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rk[3]);
    tbl[1]  = mk(1'b1, 4'd3,  1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rk[7]);
    tbl[2]  = mk(1'b1, 4'd3,  1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rk[3]);
    tbl[3]  = mk(1'b1, 4'd3,  1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rk[7]);
    tbl[4]  = mk(1'b1, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_KEY);
    tbl[5]  = mk(1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_RK1);
    tbl[6]  = mk(1'b1, 4'd10, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_RK10);
    tbl[7]  = mk(1'b1, 4'd11, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    tbl[8]  = mk(1'b1, 4'd2,  1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0);
    tbl[9]  = mk(1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tbl[10] = mk(1'b0, 4'd0,  1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_RK10);

    // reset state
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("key_ready_after_reset", bus.key_ready, 1);
    check("keys_valid_after_reset", bus.keys_valid, 0);
    bus.req0 = 1'b1;
    #1;
    check("no_grant_in_idle", bus.gnt0, 0);
    bus.req0 = 1'b0;
    tick();

    // full key expansion
    accept_key(C_KEY);
    expand(10, -1);
    check("key_ready_in_ready", bus.key_ready, 1);

    // read-port vectors
    for (int i = 0; i < 11; i++) begin
      bus.req0       = tbl[i].r0;
      bus.req0_round = tbl[i].r0n;
      bus.req1       = tbl[i].r1;
      bus.req1_round = tbl[i].r1n;
      #1;
      check($sformatf("vec%0d_gnt0", i), bus.gnt0, tbl[i].g0);
      check($sformatf("vec%0d_gnt1", i), bus.gnt1, tbl[i].g1);
      tick();
      check($sformatf("vec%0d_rd_valid", i), bus.rd_valid, tbl[i].rv);
      if (tbl[i].rv) begin
        check($sformatf("vec%0d_rd_id", i),  bus.rd_id,  tbl[i].rid);
        check($sformatf("vec%0d_rd_err", i), bus.rd_err, tbl[i].rerr);
        check($sformatf("vec%0d_rd_key", i), bus.rd_key, tbl[i].key);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // expander writes outside EXPAND must not land
    bus.exp_w_e       = 1'b1;
    bus.exp_round_no  = 4'd5;
    bus.exp_round_key = '1;
    tick();
    bus.exp_w_e = 1'b0;
    read0(4'd5, rk[5], 1'b0);
    tick();
    check("rd_valid_one_cycle", bus.rd_valid, 0);

    // key load collides with a read request: load wins, no grant until reloaded
    bus.req0       = 1'b1;
    bus.req0_round = 4'd0;
    accept_key(C_KEY);
    expand(10, -1);
    #1;
    check("gnt_after_reload", bus.gnt0, 1);
    tick();
    bus.req0 = 1'b0;
    check("reload_rd_key", bus.rd_key, C_KEY);
    tick();

    // reset during the fifth expander write
    accept_key(C_KEY);
    expand(10, 4);
    reset = 1'b1;
    #1;
    check_reset_outputs("midexp_reset");
    bus.exp_w_e  = 1'b0;
    bus.exp_done = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("key_ready_after_midexp", bus.key_ready, 1);
    check("keys_valid_after_midexp", bus.keys_valid, 0);
    accept_key(C_KEY);
    expand(0, -1);
    read0(4'd3, '0, 1'b0);
    read0(4'd0, C_KEY, 1'b0);
    tick();

`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    // zeroize mid-expansion: drain the expander, then a fresh load works
    accept_key(C_KEY);
    expand(10, 3);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zeroize_keys_valid", bus.keys_valid, 0);
    check("zeroize_exp_key", bus.exp_key, 0);
    for (int r = 4; r <= 10; r++) begin
      bus.exp_w_e       = 1'b1;
      bus.exp_round_no  = 4'(r);
      bus.exp_round_key = '1;
      bus.exp_done      = (r == 10);
      #1;
      check("drain_key_ready", bus.key_ready, 0);
      tick();
    end
    bus.exp_w_e  = 1'b0;
    bus.exp_done = 1'b0;
    check("idle_after_drain", bus.key_ready, 1);
    check("keys_valid_after_drain", bus.keys_valid, 0);
    accept_key(C_KEY);
    expand(0, -1);
    read0(4'd5, '0, 1'b0);
    read0(4'd0, C_KEY, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
